// File: rtl/lcd_regbank_pkg.sv
// lcd_reg_pkg: shared definitions for the LCD register bank.
//   - byte offsets of every register in the LCD window
//   - interrupt bit-index enum, bus state enum
//   - lcd_shadow_t: the seven double-buffered registers
package lcd_reg_pkg;

    localparam logic [11:0] OFF_TIMH          = 12'h000;
    localparam logic [11:0] OFF_TIMV          = 12'h004;
    localparam logic [11:0] OFF_POL           = 12'h008;
    localparam logic [11:0] OFF_LE            = 12'h00C;
    localparam logic [11:0] OFF_UPBASE        = 12'h010;
    localparam logic [11:0] OFF_LPBASE        = 12'h014;
    localparam logic [11:0] OFF_CTRL          = 12'h018;
    localparam logic [11:0] OFF_INTMSK        = 12'h01C;
    localparam logic [11:0] OFF_INTRAW        = 12'h020;
    localparam logic [11:0] OFF_INTSTAT       = 12'h024;
    localparam logic [11:0] OFF_INTCLR        = 12'h028;
    localparam logic [11:0] OFF_UPCURR        = 12'h02C;
    localparam logic [11:0] OFF_LPCURR        = 12'h030;
    localparam logic [11:0] OFF_PAL_BASE      = 12'h200;
    localparam logic [11:0] OFF_CRSR_CTRL     = 12'hC00;
    localparam logic [11:0] OFF_CRSR_CFG      = 12'hC04;
    localparam logic [11:0] OFF_CRSR_PAL0     = 12'hC08;
    localparam logic [11:0] OFF_CRSR_PAL1     = 12'hC0C;
    localparam logic [11:0] OFF_CRSR_XY       = 12'hC10;
    localparam logic [11:0] OFF_CRSR_CLIP     = 12'hC14;
    localparam logic [11:0] OFF_CRSR_INTMSK   = 12'hC20;
    localparam logic [11:0] OFF_CRSR_INTCLR   = 12'hC24;
    localparam logic [11:0] OFF_CRSR_INTRAW   = 12'hC28;
    localparam logic [11:0] OFF_CRSR_INTSTAT  = 12'hC2C;

    typedef enum logic [1:0] {
        IRQ_FUF   = 2'd0,
        IRQ_LNBU  = 2'd1,
        IRQ_VCOMP = 2'd2,
        IRQ_BER   = 2'd3
    } lcd_irq_idx_e;

    // The setup phase is recognised while in IDLE, so the registered
    // states only cover the cycles after it.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic [31:0] timh;
        logic [31:0] timv;
        logic [31:0] pol;
        logic [31:0] le;
        logic [31:0] upbase;
        logic [31:0] lpbase;
        logic [31:0] crsr_xy;
    } lcd_shadow_t;

endpackage

// File: rtl/lcd_regbank_if.sv
// lcd_regbank_if: APB-style slave bus of the LCD register bank.
//   master: drives psel/penable/pwrite/paddr/pwdata
//   slave : drives prdata/pready/pslverr
interface lcd_regbank_if #(
    parameter int ADDR_W = 12
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/lcd_regbank_pal_ram.sv
// lcd_pal_ram: DEPTH x 32 palette RAM.
//   port a: read/write (bus side), registered read data a_rdata
//   port b: read only (engine side), registered read data b_rdata
// Storage is not reset; only the read-data registers are.
// A read on b of a word being written on a returns the old word.
module lcd_pal_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [31:0]   b_rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end
endmodule

// File: rtl/lcd_regbank.sv
// lcd_regbank: LCD controller register bank.
//   clk, reset_n         : clock, async active-low reset
//   bus                  : APB-style slave (lcd_regbank_if.slave)
//   frame_start          : vsync pulse; shadow transfer when LcdEn=1
//   lcd_evt, crsr_evt    : interrupt event pulses
//   upcurr, lpcurr       : live DMA addresses (read-only registers)
//   timh..crsr_xy        : active copies of the shadowed registers
//   ctrl..crsr_clip      : direct register copies
//   pal_raddr/pal_rdata  : engine palette read port (1-cycle latency)
//   lcd_irq, crsr_irq    : registered interrupt lines
module lcd_regbank #(
    parameter int PAL_DEPTH   = 128,
    parameter int NUM_LCD_IRQ = 4,
    parameter int ADDR_W      = 12
) (
    input  logic                         clk,
    input  logic                         reset_n,
    lcd_regbank_if.slave                 bus,
    input  logic                         frame_start,
    input  logic [NUM_LCD_IRQ-1:0]       lcd_evt,
    input  logic                         crsr_evt,
    input  logic [31:0]                  upcurr,
    input  logic [31:0]                  lpcurr,
    output logic [31:0]                  timh,
    output logic [31:0]                  timv,
    output logic [31:0]                  pol,
    output logic [31:0]                  le,
    output logic [31:0]                  upbase,
    output logic [31:0]                  lpbase,
    output logic [31:0]                  crsr_xy,
    output logic [31:0]                  ctrl,
    output logic [31:0]                  crsr_ctrl,
    output logic [31:0]                  crsr_cfg,
    output logic [31:0]                  crsr_pal0,
    output logic [31:0]                  crsr_pal1,
    output logic [31:0]                  crsr_clip,
    input  logic [$clog2(PAL_DEPTH)-1:0] pal_raddr,
    output logic [31:0]                  pal_rdata,
    output logic                         lcd_irq,
    output logic                         crsr_irq
);
    import lcd_reg_pkg::*;

    localparam int PAL_AW = $clog2(PAL_DEPTH);

    bus_state_e             state_q, state_d;
    logic                   pready_d, pslverr_d;
    logic [31:0]            prdata_d;
    lcd_shadow_t            pend, pend_nxt, act;
    logic [NUM_LCD_IRQ-1:0] intmsk, intraw, lcd_clr;
    logic                   crsr_intmsk, crsr_intraw, crsr_clr;
    logic [ADDR_W-1:0]      a, pal_off;
    logic [PAL_AW-1:0]      pal_idx;
    logic                   pal_hit, reg_wr, pal_we, rd_err;
    logic [31:0]            rd_data, pal_a_rdata;
    logic                   unused_bits;

    // Word-aligned offset; the palette window is relative to its base.
    assign a       = {bus.paddr[ADDR_W-1:2], 2'b00};
    assign pal_off = a - ADDR_W'(OFF_PAL_BASE);
    assign pal_idx = pal_off[PAL_AW+1:2];
    assign pal_hit = (a >= ADDR_W'(OFF_PAL_BASE)) &&
                     (a <  ADDR_W'(OFF_PAL_BASE) + ADDR_W'(4 * PAL_DEPTH));
    assign unused_bits = &{1'b0, bus.paddr[1:0], pal_off};

    // Writes commit at the end of the ACCESS cycle.
    assign reg_wr = (state_q == ST_ACCESS) && bus.psel && bus.penable &&
                    bus.pwrite && !pal_hit;
    assign pal_we = (state_q == ST_ACCESS) && bus.psel && bus.penable &&
                    bus.pwrite && pal_hit;

    lcd_pal_ram #(.DEPTH(PAL_DEPTH)) u_pal (
        .clk     (clk),
        .reset_n (reset_n),
        .a_we    (pal_we),
        .a_addr  (pal_idx),
        .a_wdata (bus.pwdata),
        .a_rdata (pal_a_rdata),
        .b_addr  (pal_raddr),
        .b_rdata (pal_rdata)
    );

    // Register read mux; pending copies are what the bus sees.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (!pal_hit) begin
            case (a)
                ADDR_W'(OFF_TIMH):         rd_data = pend.timh;
                ADDR_W'(OFF_TIMV):         rd_data = pend.timv;
                ADDR_W'(OFF_POL):          rd_data = pend.pol;
                ADDR_W'(OFF_LE):           rd_data = pend.le;
                ADDR_W'(OFF_UPBASE):       rd_data = pend.upbase;
                ADDR_W'(OFF_LPBASE):       rd_data = pend.lpbase;
                ADDR_W'(OFF_CTRL):         rd_data = ctrl;
                ADDR_W'(OFF_INTMSK):       rd_data = 32'(intmsk);
                ADDR_W'(OFF_INTRAW):       rd_data = 32'(intraw);
                ADDR_W'(OFF_INTSTAT):      rd_data = 32'(intraw & intmsk);
                ADDR_W'(OFF_INTCLR):       rd_data = '0;
                ADDR_W'(OFF_UPCURR):       rd_data = upcurr;
                ADDR_W'(OFF_LPCURR):       rd_data = lpcurr;
                ADDR_W'(OFF_CRSR_CTRL):    rd_data = crsr_ctrl;
                ADDR_W'(OFF_CRSR_CFG):     rd_data = crsr_cfg;
                ADDR_W'(OFF_CRSR_PAL0):    rd_data = crsr_pal0;
                ADDR_W'(OFF_CRSR_PAL1):    rd_data = crsr_pal1;
                ADDR_W'(OFF_CRSR_XY):      rd_data = pend.crsr_xy;
                ADDR_W'(OFF_CRSR_CLIP):    rd_data = crsr_clip;
                ADDR_W'(OFF_CRSR_INTMSK):  rd_data = {31'b0, crsr_intmsk};
                ADDR_W'(OFF_CRSR_INTCLR):  rd_data = '0;
                ADDR_W'(OFF_CRSR_INTRAW):  rd_data = {31'b0, crsr_intraw};
                ADDR_W'(OFF_CRSR_INTSTAT): rd_data = {31'b0, crsr_intraw & crsr_intmsk};
                default:                   rd_err  = 1'b1;
            endcase
        end
    end

    // Bus FSM: response registers are loaded one cycle ahead so that
    // pready/prdata are valid in the ACCESS cycle itself.
    always_comb begin
        state_d   = state_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    if (pal_hit && !bus.pwrite) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d   = ST_ACCESS;
                        pready_d  = 1'b1;
                        pslverr_d = rd_err;
                        prdata_d  = (bus.pwrite || pal_hit) ? '0 : rd_data;
                    end
                end
            end
            ST_WAIT: begin
                state_d  = ST_ACCESS;
                pready_d = 1'b1;
                prdata_d = pal_a_rdata;
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
        end else begin
            state_q     <= state_d;
            bus.pready  <= pready_d;
            bus.pslverr <= pslverr_d;
            bus.prdata  <= prdata_d;
        end
    end

    // Next pending values include this cycle's write so a write landing
    // with frame_start is carried into the same transfer.
    always_comb begin
        pend_nxt = pend;
        lcd_clr  = '0;
        crsr_clr = 1'b0;
        if (reg_wr) begin
            case (a)
                ADDR_W'(OFF_TIMH):        pend_nxt.timh    = bus.pwdata;
                ADDR_W'(OFF_TIMV):        pend_nxt.timv    = bus.pwdata;
                ADDR_W'(OFF_POL):         pend_nxt.pol     = bus.pwdata;
                ADDR_W'(OFF_LE):          pend_nxt.le      = bus.pwdata;
                ADDR_W'(OFF_UPBASE):      pend_nxt.upbase  = bus.pwdata;
                ADDR_W'(OFF_LPBASE):      pend_nxt.lpbase  = bus.pwdata;
                ADDR_W'(OFF_CRSR_XY):     pend_nxt.crsr_xy = bus.pwdata;
                ADDR_W'(OFF_INTCLR):      lcd_clr  = bus.pwdata[NUM_LCD_IRQ-1:0];
                ADDR_W'(OFF_CRSR_INTCLR): crsr_clr = bus.pwdata[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend        <= '0;
            act         <= '0;
            ctrl        <= '0;
            intmsk      <= '0;
            intraw      <= '0;
            crsr_ctrl   <= '0;
            crsr_cfg    <= '0;
            crsr_pal0   <= '0;
            crsr_pal1   <= '0;
            crsr_clip   <= '0;
            crsr_intmsk <= 1'b0;
            crsr_intraw <= 1'b0;
            lcd_irq     <= 1'b0;
            crsr_irq    <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (!ctrl[0] || frame_start) begin
                act <= pend_nxt;
            end
            if (reg_wr) begin
                case (a)
                    ADDR_W'(OFF_CTRL):        ctrl        <= bus.pwdata;
                    ADDR_W'(OFF_INTMSK):      intmsk      <= bus.pwdata[NUM_LCD_IRQ-1:0];
                    ADDR_W'(OFF_CRSR_CTRL):   crsr_ctrl   <= bus.pwdata;
                    ADDR_W'(OFF_CRSR_CFG):    crsr_cfg    <= bus.pwdata;
                    ADDR_W'(OFF_CRSR_PAL0):   crsr_pal0   <= bus.pwdata;
                    ADDR_W'(OFF_CRSR_PAL1):   crsr_pal1   <= bus.pwdata;
                    ADDR_W'(OFF_CRSR_CLIP):   crsr_clip   <= bus.pwdata;
                    ADDR_W'(OFF_CRSR_INTMSK): crsr_intmsk <= bus.pwdata[0];
                    default: ;
                endcase
            end
            // Set wins over a simultaneous clear.
            intraw      <= (intraw & ~lcd_clr) | lcd_evt;
            crsr_intraw <= (crsr_intraw & ~crsr_clr) | crsr_evt;
            lcd_irq     <= |(intraw & intmsk);
            crsr_irq    <= crsr_intraw & crsr_intmsk;
        end
    end

    assign timh    = act.timh;
    assign timv    = act.timv;
    assign pol     = act.pol;
    assign le      = act.le;
    assign upbase  = act.upbase;
    assign lpbase  = act.lpbase;
    assign crsr_xy = act.crsr_xy;

endmodule

// File: tb/tb_lcd_regbank.sv
// tb_lcd_regbank: directed-vector bench for lcd_regbank.
module tb_lcd_regbank;
    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic [3:0]  lcd_evt;
    logic        crsr_evt;
    logic [31:0] upcurr, lpcurr;
    logic [31:0] timh, timv, pol, le, upbase, lpbase, crsr_xy;
    logic [31:0] ctrl, crsr_ctrl, crsr_cfg, crsr_pal0, crsr_pal1, crsr_clip;
    logic [6:0]  pal_raddr;
    logic [31:0] pal_rdata;
    logic        lcd_irq, crsr_irq;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] rdat;
    logic        rerr;
    int          rwait;

    logic [11:0] map_offs [23] = '{
        12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C,
        12'h020, 12'h024, 12'h028, 12'h02C, 12'h030,
        12'hC00, 12'hC04, 12'hC08, 12'hC0C, 12'hC10, 12'hC14,
        12'hC20, 12'hC24, 12'hC28, 12'hC2C};

    lcd_regbank_if #(.ADDR_W(12)) bus ();

    lcd_regbank dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .frame_start(frame_start), .lcd_evt(lcd_evt), .crsr_evt(crsr_evt),
        .upcurr(upcurr), .lpcurr(lpcurr),
        .timh(timh), .timv(timv), .pol(pol), .le(le),
        .upbase(upbase), .lpbase(lpbase), .crsr_xy(crsr_xy),
        .ctrl(ctrl), .crsr_ctrl(crsr_ctrl), .crsr_cfg(crsr_cfg),
        .crsr_pal0(crsr_pal0), .crsr_pal1(crsr_pal1), .crsr_clip(crsr_clip),
        .pal_raddr(pal_raddr), .pal_rdata(pal_rdata),
        .lcd_irq(lcd_irq), .crsr_irq(crsr_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One APB transfer; evt/fs are pulsed during the access phase.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] evt, input logic fs,
                        output logic [31:0] rd, output logic er, output int waits);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = wd;
        @(posedge clk); #1;
        bus.penable = 1'b1; lcd_evt = evt; frame_start = fs;
        waits = 0;
        while (!bus.pready && waits < 8) begin
            @(posedge clk); #1;
            lcd_evt = '0; frame_start = 1'b0;
            waits++;
        end
        nvec++;
        if (!bus.pready) begin
            nerr++;
            $display("FAIL pready_timeout addr=%h: got pready=0 required 1", addr);
        end
        rd = bus.prdata; er = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        lcd_evt = '0; frame_start = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] d; logic e; int w;
        xfer(1'b1, addr, wd, 4'h0, 1'b0, d, e, w);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({bus.pready, bus.pslverr, lcd_irq, crsr_irq} !== 4'b0 || bus.prdata !== 32'h0) begin
            nerr++;
            $display("FAIL reset_bus_irq: got rdy/err/irq=%b prdata=%h required 0", {bus.pready, bus.pslverr, lcd_irq, crsr_irq}, bus.prdata);
        end
        nvec++;
        if ({timh, upbase, crsr_xy, ctrl, crsr_ctrl, pal_rdata} !== 192'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got timh=%h upbase=%h ctrl=%h pal_rdata=%h required 0", timh, upbase, ctrl, pal_rdata);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 23; i++) begin
            xfer(1'b0, map_offs[i], 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
            nvec++;
            if (rdat !== 32'h0 || rerr !== 1'b0) begin
                nerr++;
                $display("FAIL reset_read %h: got data=%h err=%b required 0/0", map_offs[i], rdat, rerr);
            end
        end
        xfer(1'b0, 12'h034, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h0 || rerr !== 1'b1) begin
            nerr++;
            $display("FAIL unmapped_read: got data=%h err=%b required 0/1", rdat, rerr);
        end
    endtask

    task automatic test_shadow_disabled();
        wr(12'h000, 32'h1234_5678);
        nvec++;
        if (timh !== 32'h1234_5678) begin
            nerr++;
            $display("FAIL timh_lcden0: got %h required 12345678", timh);
        end
        wr(12'h004, 32'h0BAD_F00D);
        wr(12'hC10, 32'h0040_0020);
        nvec++;
        if (timv !== 32'h0BAD_F00D || crsr_xy !== 32'h0040_0020) begin
            nerr++;
            $display("FAIL timv_crsrxy: got %h %h required 0badf00d 00400020", timv, crsr_xy);
        end
        xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h0BAD_F00D) begin
            nerr++;
            $display("FAIL timv_read: got %h required 0badf00d", rdat);
        end
    endtask

    task automatic test_regs_misc();
        wr(12'h01C, 32'hFFFF_FFFF);
        xfer(1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h0000_000F) begin
            nerr++;
            $display("FAIL intmsk_width: got %h required 0000000f", rdat);
        end
        xfer(1'b1, 12'h020, 32'hF, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rerr !== 1'b0) begin
            nerr++;
            $display("FAIL ro_write_err: got %b required 0", rerr);
        end
        xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h0) begin
            nerr++;
            $display("FAIL ro_write_ignored: got %h required 0", rdat);
        end
        upcurr = 32'h1111_2222; lpcurr = 32'h3333_4444;
        xfer(1'b0, 12'h030, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h3333_4444) begin
            nerr++;
            $display("FAIL lpcurr_read: got %h required 33334444", rdat);
        end
        xfer(1'b1, 12'h034, 32'hFFFF_FFFF, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rerr !== 1'b1) begin
            nerr++;
            $display("FAIL unmapped_write_err: got %b required 1", rerr);
        end
        wr(12'hC00, 32'h0000_0003);
        nvec++;
        if (crsr_ctrl !== 32'h3) begin
            nerr++;
            $display("FAIL crsr_ctrl: got %h required 00000003", crsr_ctrl);
        end
    endtask

    task automatic test_shadow_enabled();
        wr(12'h018, 32'h0000_0001);
        wr(12'h010, 32'hA000_0000);
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (upbase !== 32'h0) begin
            nerr++;
            $display("FAIL upbase_held: got %h required 0", upbase);
        end
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'hA000_0000) begin
            nerr++;
            $display("FAIL upbase_pending_read: got %h required a0000000", rdat);
        end
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        nvec++;
        if (upbase !== 32'hA000_0000) begin
            nerr++;
            $display("FAIL upbase_frame: got %h required a0000000", upbase);
        end
        xfer(1'b1, 12'h014, 32'hB000_0000, 4'h0, 1'b1, rdat, rerr, rwait);
        nvec++;
        if (lpbase !== 32'hB000_0000) begin
            nerr++;
            $display("FAIL lpbase_same_cycle: got %h required b0000000", lpbase);
        end
        wr(12'h018, 32'h0);
    endtask

    task automatic test_irq();
        wr(12'h01C, 32'h4);
        @(posedge clk); #1; lcd_evt = 4'h4;
        @(posedge clk); #1; lcd_evt = 4'h0;
        nvec++;
        if (lcd_irq !== 1'b0) begin
            nerr++;
            $display("FAIL irq_early: got %b required 0", lcd_irq);
        end
        @(posedge clk); #1;
        nvec++;
        if (lcd_irq !== 1'b1) begin
            nerr++;
            $display("FAIL irq_latency: got %b required 1", lcd_irq);
        end
        xfer(1'b1, 12'h028, 32'h4, 4'h4, 1'b0, rdat, rerr, rwait);
        xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h4 || lcd_irq !== 1'b1) begin
            nerr++;
            $display("FAIL set_beats_clear: got raw=%h irq=%b required 4/1", rdat, lcd_irq);
        end
        wr(12'h028, 32'h4);
        nvec++;
        if (lcd_irq !== 1'b1) begin
            nerr++;
            $display("FAIL clear_n1: got %b required 1", lcd_irq);
        end
        @(posedge clk); #1;
        nvec++;
        if (lcd_irq !== 1'b0) begin
            nerr++;
            $display("FAIL clear_n2: got %b required 0", lcd_irq);
        end
        @(posedge clk); #1; lcd_evt = 4'h1;
        @(posedge clk); #1; lcd_evt = 4'h0;
        xfer(1'b0, 12'h024, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h0 || lcd_irq !== 1'b0) begin
            nerr++;
            $display("FAIL masked_src: got stat=%h irq=%b required 0/0", rdat, lcd_irq);
        end
        xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h1) begin
            nerr++;
            $display("FAIL masked_raw: got %h required 00000001", rdat);
        end
        wr(12'h028, 32'hF);
    endtask

    task automatic test_crsr_irq();
        wr(12'hC20, 32'h1);
        @(posedge clk); #1; crsr_evt = 1'b1;
        @(posedge clk); #1; crsr_evt = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if (crsr_irq !== 1'b1) begin
            nerr++;
            $display("FAIL crsr_irq: got %b required 1", crsr_irq);
        end
        xfer(1'b0, 12'hC2C, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h1) begin
            nerr++;
            $display("FAIL crsr_intstat: got %h required 00000001", rdat);
        end
    endtask

    task automatic test_palette();
        xfer(1'b1, 12'h214, 32'hDEAD_BEEF, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rwait !== 0) begin
            nerr++;
            $display("FAIL pal_write_waits: got %0d required 0", rwait);
        end
        xfer(1'b0, 12'h214, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'hDEAD_BEEF || rwait !== 1) begin
            nerr++;
            $display("FAIL pal_read: got %h waits=%0d required deadbeef waits=1", rdat, rwait);
        end
        pal_raddr = 7'd5;
        @(posedge clk); #1;
        nvec++;
        if (pal_rdata !== 32'hDEAD_BEEF) begin
            nerr++;
            $display("FAIL pal_engine: got %h required deadbeef", pal_rdata);
        end
        wr(12'h214, 32'h1234_5678);
        nvec++;
        if (pal_rdata !== 32'hDEAD_BEEF) begin
            nerr++;
            $display("FAIL pal_collision_old: got %h required deadbeef", pal_rdata);
        end
        @(posedge clk); #1;
        nvec++;
        if (pal_rdata !== 32'h1234_5678) begin
            nerr++;
            $display("FAIL pal_collision_new: got %h required 12345678", pal_rdata);
        end
        wr(12'h3FC, 32'hCAFE_0127);
        xfer(1'b0, 12'h3FC, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'hCAFE_0127 || rerr !== 1'b0) begin
            nerr++;
            $display("FAIL pal_last: got %h err=%b required cafe0127/0", rdat, rerr);
        end
        xfer(1'b0, 12'h400, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rerr !== 1'b1 || rdat !== 32'h0) begin
            nerr++;
            $display("FAIL pal_past_end: got %h err=%b required 0/1", rdat, rerr);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 12'h214;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        nvec++;
        if (bus.pready !== 1'b0) begin
            nerr++;
            $display("FAIL mid_wait_state: got pready=%b required 0", bus.pready);
        end
        reset_n = 1'b0;
        #1;
        nvec++;
        if ({bus.pready, bus.pslverr, lcd_irq, crsr_irq} !== 4'b0 || bus.prdata !== 32'h0 ||
            pal_rdata !== 32'h0 || timh !== 32'h0 || crsr_ctrl !== 32'h0) begin
            nerr++;
            $display("FAIL mid_reset_outputs: got rdy/err/irq=%b pal=%h timh=%h crsr_ctrl=%h required 0",
                     {bus.pready, bus.pslverr, lcd_irq, crsr_irq}, pal_rdata, timh, crsr_ctrl);
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        xfer(1'b0, 12'h214, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h1234_5678 || rwait !== 1) begin
            nerr++;
            $display("FAIL post_reset_pal: got %h waits=%0d required 12345678 waits=1", rdat, rwait);
        end
        xfer(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, rdat, rerr, rwait);
        nvec++;
        if (rdat !== 32'h0) begin
            nerr++;
            $display("FAIL post_reset_timh: got %h required 0", rdat);
        end
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; lcd_evt = '0; crsr_evt = 1'b0;
        upcurr = '0; lpcurr = '0; pal_raddr = '0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        test_reset();
        test_shadow_disabled();
        test_regs_misc();
        test_shadow_enabled();
        test_irq();
        test_crsr_irq();
        test_palette();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
